// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared CPU front-end definitions.
// Holds the XLEN, the NOP encoding used for misaligned-target markers,
// the fetch-queue entry layout and the fetch state encoding.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            misalign;
   } fetch_entry_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/cpu_fetch_fifo.sv
// cpu_fetch_fifo -- synchronous fetch queue with flush.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush_i           drop all entries at this edge (wins over push/pop)
//   push_i, data_i    write an entry
//   pop_i             remove the head (only when valid_o)
//   data_o, valid_o   head entry (zero when empty) and its valid
//   count_o           number of stored entries
// Pointers are log2(DEPTH) bits and wrap by natural rollover, so DEPTH
// must be a power of two.
module cpu_fetch_fifo #(
   parameter  int WIDTH = 65,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_en;
   logic             rd_en;

   assign wr_en = push_i & ~flush_i;
   assign rd_en = pop_i & ~flush_i & (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
   end

   assign valid_o = (count_q != '0);
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit -- instruction fetch front end with redirect support.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   imem_en, imem_addr    memory read request / word address
//   imem_rdata            read data, valid one cycle after imem_en
//   redir_valid, redir_pc redirect request and target
//   f_valid, f_ready      head handshake toward the decoder
//   f_instr, f_pc         head instruction and its address
//   f_misalign            head is a misaligned-target marker (macro only)
// Optional feature: define FETCH_MISALIGN_CHK_EN to turn a misaligned
// redirect into a NOP marker entry and halt fetching until the next
// redirect. Without it the low target bits are ignored.
//
// state   | meaning
// RUN     | issuing reads while queue credit is available
// HALT    | misaligned target seen; no issue until next redirect
module cpu_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          IMEM_AW     = 10,
   parameter int          QUEUE_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_en,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   input  logic               redir_valid,
   input  logic [31:0]        redir_pc,
   output logic               f_valid,
   input  logic               f_ready,
   output logic [31:0]        f_instr,
   output logic [31:0]        f_pc
`ifdef FETCH_MISALIGN_CHK_EN
   ,
   output logic               f_misalign
`endif
);

   localparam int CW = $clog2(QUEUE_DEPTH);

   logic [31:0]  pc_q, pc_d;
   logic         inflight_q, inflight_d;
   logic [31:0]  inflight_pc_q, inflight_pc_d;
   logic [CW:0]  q_count;
   logic [CW+1:0] occupancy;
   logic         q_valid;
   logic         run;
   logic         issue;
   logic         push;
   logic         pop;
   logic [31:0]  redir_target;
   fetch_entry_t push_entry;
   fetch_entry_t head_entry;

`ifdef FETCH_MISALIGN_CHK_EN
   fetch_state_e state_q, state_d;
   logic         mis_pend_q, mis_pend_d;
   logic         redir_misaligned;

   assign redir_misaligned = (redir_pc[1:0] != 2'b00);
   assign redir_target     = redir_pc;
   assign run              = (state_q == ST_RUN);

   always_comb begin
      state_d    = state_q;
      mis_pend_d = 1'b0;
      if (redir_valid) begin
         state_d    = redir_misaligned ? ST_HALT : ST_RUN;
         mis_pend_d = redir_misaligned;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         mis_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mis_pend_q <= mis_pend_d;
      end
   end

   // The marker reuses pc_q, which holds the raw misaligned target.
   assign push = (inflight_q | mis_pend_q) & ~redir_valid;
   always_comb begin
      if (mis_pend_q) begin
         push_entry = '{pc: pc_q, instr: NOP_INSTR, misalign: 1'b1};
      end else begin
         push_entry = '{pc: inflight_pc_q, instr: imem_rdata, misalign: 1'b0};
      end
   end
`else
   logic redir_lsb_unused;

   assign redir_lsb_unused = ^redir_pc[1:0];
   assign redir_target     = {redir_pc[31:2], 2'b00};
   assign run              = 1'b1;
   assign push             = inflight_q & ~redir_valid;
   assign push_entry       = '{pc: inflight_pc_q, instr: imem_rdata, misalign: 1'b0};
`endif

   // Credit counts the in-flight read; a same-cycle pop is not credited.
   assign occupancy = {1'b0, q_count} + (CW+2)'(inflight_q);
   assign issue     = rst_n & run & ~redir_valid
                      & (occupancy < (CW+2)'(QUEUE_DEPTH));

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (redir_valid) begin
         pc_d = redir_target;
      end else if (issue) begin
         pc_d          = pc_q + 32'd4;
         inflight_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   cpu_fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redir_valid),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head_entry),
      .valid_o (q_valid),
      .count_o (q_count)
   );

   assign imem_en   = issue;
   assign imem_addr = pc_q[IMEM_AW+1:2];
   assign f_valid   = q_valid & ~redir_valid;
   assign pop       = f_valid & f_ready;
   assign f_instr   = head_entry.instr;
   assign f_pc      = head_entry.pc;
`ifdef FETCH_MISALIGN_CHK_EN
   assign f_misalign = head_entry.misalign;
`endif

endmodule

// File: doc/cpu_fetch_unit.md
CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset.
REQ-002 Parameter IMEM_AW, default 10: instruction-memory word-address width.
REQ-003 Parameter QUEUE_DEPTH, default 4: fetch-queue entries; power of two, >=2.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 imem_en  out  1  read request this cycle.
REQ-007 imem_addr  out  IMEM_AW  word address, = pc[IMEM_AW+1:2].
REQ-008 imem_rdata  in  32  read data, valid exactly one cycle after imem_en.
REQ-009 redir_valid  in  1  redirect request (branch/jump/trap).
REQ-010 redir_pc  in  32  redirect target.
REQ-011 f_valid  out  1  queue head valid.
REQ-012 f_ready  in  1  consumer accepts head.
REQ-013 f_instr  out  32  head instruction.
REQ-014 f_pc  out  32  head instruction address.
REQ-015 f_misalign  out  1  head is a misaligned-target marker (present only with FETCH_MISALIGN_CHK_EN).

Function
REQ-016 States RUN and HALT; reset enters RUN; HALT exists only with FETCH_MISALIGN_CHK_EN.
REQ-017 imem_en SHALL be 1 iff state RUN, redir_valid=0, and (queue count + in-flight count) < QUEUE_DEPTH; same-cycle pop not credited.
REQ-018 Each issue SHALL advance pc by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 A response not killed SHALL be pushed in the cycle after its issue, tagged with its issue pc.
REQ-020 Issue-to-f_valid latency SHALL be 2 cycles; program order preserved; no entry dropped or duplicated.
REQ-021 Transfer occurs when f_valid & f_ready; queue pops that edge; head holds stable while f_valid & ~f_ready.
REQ-022 f_valid SHALL be forced 0 while redir_valid=1; no transfer in a redirect cycle.
REQ-023 Redirect SHALL, at that edge: flush queue, kill the in-flight response, load pc <= redir_pc; first new issue next cycle.
REQ-024 Back-to-back redirects: last one wins; each kills all earlier traffic.
REQ-025 Redirect in HALT SHALL return state to RUN (if target aligned).
REQ-026 Simultaneous push and pop with queue non-empty SHALL keep count unchanged.

Reset
REQ-027 On rst_n low: pc=RESET_PC, queue empty, in-flight cleared, state RUN, imem_en=0, f_valid=0, f_instr=0, f_pc=0, f_misalign=0.
REQ-028 Reset mid-operation SHALL discard all queued and in-flight data; the first issue after release uses RESET_PC.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHK_EN defined: redirect with redir_pc[1:0]!=0 SHALL push one entry {f_pc=redir_pc, f_instr=32'h0000_0013, f_misalign=1} in the next cycle, enter HALT, and issue nothing until the next redirect.
REQ-030 Macro undefined: redir_pc[1:0] ignored (treated as 2'b00), no HALT state, f_misalign port absent.

Structure
REQ-031 Shared package cpu_pkg SHALL hold NOP encoding 32'h0000_0013, XLEN=32, and the fetch-entry type {pc, instr, misalign}.
REQ-032 Queue SHALL be sub-module cpu_fetch_fifo (parametrised width/depth, flush input, count output); pointer wrap by depth-bit rollover.

Verification
REQ-033 Reset release, RESET_PC=32'h100, f_ready=1, memory word n = n -> imem_en cycle 0; f_valid cycle 2 with f_pc=32'h100; then 32'h104, 32'h108 every cycle.
REQ-034 f_ready=0 for 10 cycles -> exactly 4 entries queued, imem_en low once full; release -> 4 queued entries drain in order, none lost.
REQ-035 Redirect to 32'h40 while queue holds 3 entries and one in flight -> f_valid=0 that cycle, next 4 transfers have f_pc 32'h40, 44, 48, 4C.
REQ-036 pc=32'hFFFF_FFF8 fetching continuously -> f_pc sequence ...FFF8, ...FFFC, 32'h0000_0000.
REQ-037 With macro: redirect to 32'h42 -> one entry f_pc=32'h42, f_instr=32'h13, f_misalign=1; imem_en stays 0; redirect to 32'h80 resumes.
REQ-038 rst_n pulsed low mid-stream with queue full -> f_valid=0 immediately; restart from RESET_PC; no stale entry observed.
